// File: rtl/dot_product_acc.sv
// dot_product_acc: streaming signed 8x8 dot-product engine.
// Takes LEN (m, q) pairs over valid/ready and multiplies each pair into a
// registered product. Products are summed into a saturating ACC_W-bit
// accumulator. The finished sum is held on a valid/ready output port until
// the consumer takes it.
module dot_product_acc #(
  parameter int LEN   = 4,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_m,
  input  logic [7:0]       in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  // The counter only needs to reach LEN-1. It wraps harmlessly on the last
  // accept because the handshake clears it before the next dot product.
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [15:0]        p_reg;
  logic               p_vld_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic               ovf_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;

  logic signed [15:0] prod_next;
  logic [ACC_W:0]     sum_ext;
  logic               sat_hi;
  logic               sat_lo;
  logic [ACC_W-1:0]   acc_next;
  logic               sat_next;

  // Both operands are widened to 16 bits first. This keeps the corner case
  // (-128)*(-128) = +16384 exact.
  assign prod_next = $signed({{8{in_m[7]}}, in_m}) * $signed({{8{in_q[7]}}, in_q});

  // Saturating add of the pending product, computed one bit wider than the
  // accumulator. The top two sum bits disagree exactly when the true sum
  // leaves the representable range; the MSB then gives the clamp direction.
  always_comb begin
    sum_ext  = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W-15){p_reg[15]}}, p_reg};
    sat_hi   = (sum_ext[ACC_W:ACC_W-1] == 2'b01);
    sat_lo   = (sum_ext[ACC_W:ACC_W-1] == 2'b10);
    sat_next = sat_hi | sat_lo;
    acc_next = sum_ext[ACC_W-1:0];
    if (sat_hi) begin
      acc_next = ACC_MAX;
    end else if (sat_lo) begin
      acc_next = ACC_MIN;
    end
  end

  // Control FSM, product stage and accumulator. The handshake outputs are
  // registered alongside the state, so no input reaches an output
  // combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      cnt_reg       <= '0;
      p_reg         <= '0;
      p_vld_reg     <= 1'b0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      // Every valid product is folded in one cycle after it was formed.
      // The sticky flag only ever sets here; the result handshake clears it.
      if (p_vld_reg) begin
        acc_reg <= acc_next;
        if (sat_next) begin
          ovf_reg <= 1'b1;
        end
      end

      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            p_reg     <= prod_next;
            p_vld_reg <= 1'b1;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
            end
          end else begin
            p_vld_reg <= 1'b0;
          end
        end

        // The last product is added on this edge, so the sum is complete
        // when OUT is entered.
        DRAIN: begin
          p_vld_reg     <= 1'b0;
          state_reg     <= OUT;
          out_valid_reg <= 1'b1;
        end

        OUT: begin
          if (out_ready) begin
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= ACCUM;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_acc   = acc_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_dot_product_acc.sv
// Testbench for dot_product_acc. Four instances with different LEN/ACC_W
// share one clock. A transaction-level model predicts, on every cycle, the
// handshake outputs and the result of each instance. Directed tests pin the
// model with hand-computed literals.
module tb_dot_product_acc;

  localparam int NI = 4;
  localparam int LEN_T [NI] = '{4, 2, 3, 4};
  localparam int W_T   [NI] = '{16, 20, 20, 20};

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic               vld  [NI];
  logic               rdy  [NI];
  logic signed [7:0]  mm   [NI];
  logic signed [7:0]  qq   [NI];
  logic               ov   [NI];
  logic               ordy [NI];
  logic signed [31:0] acc_s[NI];
  logic               ovf_v[NI];

  int checks   = 0;
  int failures = 0;
  int acc_cyc [NI];

  // Model state per instance.
  longint m_sum  [NI];
  bit     m_ovf  [NI];
  int     m_cnt  [NI];
  bit     m_done [NI];
  int     m_age  [NI];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = W_T[gi];
    logic         rdy_w;
    logic         ov_w;
    logic         ovf_w;
    logic [W-1:0] acc_w;

    dot_product_acc #(.LEN(LEN_T[gi]), .ACC_W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[gi]),
      .in_ready  (rdy_w),
      .in_m      (mm[gi]),
      .in_q      (qq[gi]),
      .out_valid (ov_w),
      .out_ready (ordy[gi]),
      .out_acc   (acc_w),
      .out_ovf   (ovf_w)
    );

    assign rdy[gi]   = rdy_w;
    assign ov[gi]    = ov_w;
    assign ovf_v[gi] = ovf_w;
    assign acc_s[gi] = 32'(signed'(acc_w));
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model of the specified behaviour. A dot product completes when its LEN-th
  // pair is accepted. in_ready is low from that point until the result
  // handshake, and the result is offered from the second cycle after the
  // last accept. Sums saturate after every add, in acceptance order.
  always @(negedge clk) begin
    bit     e_rdy;
    bit     e_ov;
    longint s;
    longint lo;
    longint hi;
    for (int i = 0; i < NI; i++) begin
      e_rdy = !m_done[i];
      e_ov  = m_done[i] && (m_age[i] >= 1);
      check($sformatf("u%0d_in_ready", i), longint'(rdy[i]), longint'(e_rdy));
      check($sformatf("u%0d_out_valid", i), longint'(ov[i]), longint'(e_ov));
      if (e_ov) begin
        check($sformatf("u%0d_out_acc", i), longint'(acc_s[i]), m_sum[i]);
        check($sformatf("u%0d_out_ovf", i), longint'(ovf_v[i]), longint'(m_ovf[i]));
      end

      // Advance the model across the coming rising edge.
      if (!rst_n) begin
        m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_age[i] = 0;
      end else if (m_done[i]) begin
        if (e_ov && ordy[i]) begin
          m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
      end else if (vld[i]) begin
        hi = (longint'(1) <<< (W_T[i] - 1)) - 1;
        lo = -(longint'(1) <<< (W_T[i] - 1));
        s  = m_sum[i] + longint'(mm[i]) * longint'(qq[i]);
        if (s > hi) begin s = hi; m_ovf[i] = 1; end
        if (s < lo) begin s = lo; m_ovf[i] = 1; end
        m_sum[i] = s;
        m_cnt[i]++;
        if (m_cnt[i] == LEN_T[i]) begin
          m_done[i] = 1;
          m_age[i]  = 0;
        end
      end
    end
  end

  // Present one pair and hold it until accepted.
  task automatic send(input int i, input int m, input int q);
    int g;
    bit took;
    g = 0;
    took = 0;
    vld[i] = 1'b1;
    mm[i] = 8'(m);
    qq[i] = 8'(q);
    while (!took && g < 100) begin
      @(negedge clk);
      if (rdy[i]) begin
        took = 1;
        acc_cyc[i] = cyc;
      end
      @(posedge clk);
      #1;
      g++;
    end
    vld[i] = 1'b0;
    if (!took) check($sformatf("u%0d_send_timeout", i), longint'(took), 1);
  endtask

  // Wait for the result handshake and return what was transferred.
  task automatic get_result(input int i, output longint racc, output longint rovf,
                            output int rcyc);
    int g;
    bit got;
    g = 0;
    got = 0;
    racc = 0;
    rovf = 0;
    rcyc = 0;
    while (!got && g < 100) begin
      @(negedge clk);
      if (ov[i] && ordy[i]) begin
        got  = 1;
        racc = longint'(acc_s[i]);
        rovf = longint'(ovf_v[i]);
        rcyc = cyc;
      end
      @(posedge clk);
      #1;
      g++;
    end
    if (!got) check($sformatf("u%0d_result_timeout", i), longint'(got), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ra;
    longint rf;
    int     rc;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; mm[i] = '0; qq[i] = '0; ordy[i] = 1'b1;
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_u%0d_in_ready", i), longint'(rdy[i]), 1);
      check($sformatf("rst_u%0d_out_valid", i), longint'(ov[i]), 0);
      check($sformatf("rst_u%0d_out_acc", i), longint'(acc_s[i]), 0);
      check($sformatf("rst_u%0d_out_ovf", i), longint'(ovf_v[i]), 0);
    end
    @(posedge clk);
    #1;

    // Basic dot product with corner products, ACC_W=20.
    send(3, 3, 4); send(3, -5, 6); send(3, 127, 127); send(3, -128, -128);
    get_result(3, ra, rf, rc);
    check("basic_acc", ra, 32495);
    check("basic_ovf", rf, 0);
    check("basic_latency", longint'(rc - acc_cyc[3]), 2);
    @(negedge clk);
    check("basic_one_cycle_wide", longint'(ov[3]), 0);
    @(posedge clk);
    #1;

    // Positive saturation, then sticky flag cleared for the next product.
    for (int k = 0; k < 4; k++) send(0, -128, -128);
    get_result(0, ra, rf, rc);
    check("possat_acc", ra, 32767);
    check("possat_ovf", rf, 1);
    for (int k = 0; k < 4; k++) send(0, 1, 1);
    get_result(0, ra, rf, rc);
    check("after_sat_acc", ra, 4);
    check("after_sat_ovf", rf, 0);

    // Negative saturation.
    for (int k = 0; k < 4; k++) send(0, -128, 127);
    get_result(0, ra, rf, rc);
    check("negsat_acc", ra, -32768);
    check("negsat_ovf", rf, 1);

    // Backpressure holds the result and blocks input.
    ordy[1] = 1'b0;
    send(1, 2, 3); send(1, 4, 5);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), longint'(ov[1]), 1);
      check($sformatf("bp_acc_%0d", k), longint'(acc_s[1]), 26);
      check($sformatf("bp_in_ready_%0d", k), longint'(rdy[1]), 0);
      @(posedge clk);
      #1;
    end
    ordy[1] = 1'b1;
    get_result(1, ra, rf, rc);
    check("bp_result", ra, 26);
    @(negedge clk);
    check("bp_in_ready_after", longint'(rdy[1]), 1);
    @(posedge clk);
    #1;

    // Continuous stream, LEN=3: one result of 3 every 5 cycles.
    vld[2] = 1'b1; mm[2] = 8'sd1; qq[2] = 8'sd1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("stream_in_ready_%0d", k), longint'(rdy[2]), longint'((k % 5) < 3));
      check($sformatf("stream_valid_%0d", k), longint'(ov[2]), longint'((k % 5) == 4));
      if ((k % 5) == 4) check($sformatf("stream_acc_%0d", k), longint'(acc_s[2]), 3);
    end
    @(posedge clk);
    #1;
    vld[2] = 1'b0;

    // Reset in the middle of a dot product discards the partial sum.
    send(0, 10, 10); send(0, 10, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid_during", longint'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid_after", longint'(ov[0]), 0);
    check("midrst_in_ready_after", longint'(rdy[0]), 1);
    check("midrst_acc_after", longint'(acc_s[0]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send(0, 1, 2);
    get_result(0, ra, rf, rc);
    check("midrst_acc", ra, 8);
    check("midrst_ovf", rf, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_acc.md
# dot_product_acc

Streaming signed 8x8 dot-product engine that sits directly upstream of the team's consumers of multiplier products and directly downstream of the operand source. It accepts LEN operand pairs (m, q) over a valid/ready handshake and multiplies each pair in a registered product stage. It then accumulates the 16-bit products into a saturating ACC_W-bit accumulator and presents the finished sum on a valid/ready output port. It is the accumulate stage that turns single products into dot products.

## Interface
- LEN, default 4: operand pairs per dot product; legal 1..256.
- ACC_W, default 20: accumulator/result width in bits; legal 16..32.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts a pair this cycle
- in_m  in  8  signed multiplicand
- in_q  in  8  signed multiplier
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result this cycle
- out_acc  out  ACC_W  signed dot-product result
- out_ovf  out  1  sticky: saturation occurred during this dot product

## Operation
- States: ACCUM, DRAIN, OUT. Reset state ACCUM.
- ACCUM: in_ready=1. Accept on in_valid&&in_ready. On accept: p_reg <= in_m*in_q (signed 16-bit), p_vld <= 1, cnt <= cnt+1. No accept: p_vld <= 0. Accept with cnt==LEN-1 -> DRAIN.
- DRAIN: in_ready=0. Add final p_reg, clear p_vld -> OUT.
- OUT: in_ready=0, out_valid=1. out_acc/out_ovf held stable until out_ready. On out_valid&&out_ready: acc<=0, ovf<=0, cnt<=0 -> ACCUM.
- Accumulate every cycle p_vld=1: acc <= sat(acc + sext(p_reg)). Compute sum in ACC_W+1 bits. Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Set ovf on clamp. ovf stays set until result handshake. Later adds start from the clamped value.
- Product range: -16256..16384 ((-128)*(-128)=16384 must be exact, no wrap).
- out_acc = acc; out_ovf = ovf. Both are visible in all states but meaningful only while out_valid.
- in_m/in_q are ignored when no accept occurs.

## Timing
- Reset (rst_n=0 at a rising edge): state=ACCUM, cnt=0, acc=0, ovf=0, p_reg=0, p_vld=0. Outputs after reset: in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
- Reset mid-operation, in any state: partial sum and pending product are discarded. No output is produced for that dot product.
- in_ready and out_valid are decoded from registered state only. There is no combinational in->out path.
- Latency: last pair accepted at edge E0. DRAIN after E0, OUT after E1, so out_valid is high 2 cycles after the last accept.
- Throughput: with in_valid and out_ready tied high, one result every LEN+2 cycles. in_ready is high LEN of every LEN+2 cycles.
- Backpressure: out_ready low holds OUT indefinitely. in_ready stays 0, and out_acc/out_ovf do not change.
- Pairs accepted back-to-back in ACCUM accumulate with a 1-cycle lag. There is no bubble between accept and product.
- LEN=1: accept -> DRAIN -> OUT; out_valid 2 cycles after accept.

## Test plan
- LEN=4, ACC_W=20, pairs (3,4),(-5,6),(127,127),(-128,-128), out_ready=1 -> out_acc=32495, out_ovf=0, out_valid exactly 2 cycles after 4th accept, 1 cycle wide.
- ACC_W=16, LEN=4, four pairs (-128,-128), then a second dot product of (1,1)x4 -> first result out_acc=32767, out_ovf=1; second out_acc=4, out_ovf=0 (ovf cleared).
- Negative saturation, ACC_W=16, LEN=4, pairs (-128,127)x4 -> sum -65024 clamps to out_acc=-32768, out_ovf=1.
- Backpressure: LEN=2, pairs (2,3),(4,5), out_ready=0 for 5 cycles -> out_valid=1 and out_acc=26 stable, in_ready=0 throughout. out_ready=1 -> handshake; in_ready=1 next cycle.
- Continuous stream: LEN=3, in_valid=1 always, in_m=in_q=1, out_ready=1 -> out_acc=3 every 5 cycles, in_ready pattern 1,1,1,0,0 repeating.
- Reset mid-op: LEN=4, accept 2 pairs (10,10), assert rst_n=0 for 1 cycle, then send (1,2)x4 -> out_acc=8, no stale 200 contribution; out_valid=0 during and after reset.
